// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI master between NUM_REQ requesters.
// One SPI transaction per grant; completion or timeout is reported to the owner.
module spi_master_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*16-1:0]  req_cmd,
  input  logic [NUM_REQ*16-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [NUM_REQ-1:0]     req_done,
  output logic [NUM_REQ-1:0]     req_err,
  output logic [15:0]            req_rdata,
  output logic [2:0]             owner,
  output logic                   arb_busy,
  output logic                   m_start_tx,
  output logic [15:0]            m_cmd_packet,
  output logic [15:0]            m_data_wr,
  input  logic                   m_spi_busy,
  input  logic                   m_tx_done,
  input  logic [15:0]            m_data_rd
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..8");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state;
  logic [2:0]      ptr;
  logic [CW-1:0]   cnt;

  logic            hit;
  logic [2:0]      sel;
  logic [2:0]      pos;
  logic [2:0]      nxt_ptr;
  logic [15:0]     cmd_sel;
  logic [15:0]     wdata_sel;
  logic [NUM_REQ-1:0] sel_oh;
  logic [NUM_REQ-1:0] own_oh;

  function automatic logic [2:0] wrap(input logic [3:0] v);
    return (v >= 4'(NUM_REQ)) ? 3'(v - 4'(NUM_REQ)) : v[2:0];
  endfunction

  // First valid requester scanning ptr, ptr+1, ... modulo NUM_REQ.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    pos = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      pos = wrap({1'b0, ptr} + 4'(j));
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!hit && pos == 3'(k) && req_valid[k]) begin
          hit = 1'b1;
          sel = pos;
        end
      end
    end
  end

  always_comb begin
    cmd_sel   = '0;
    wdata_sel = '0;
    sel_oh    = '0;
    own_oh    = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (sel == 3'(j)) begin
        cmd_sel   = req_cmd[16*j +: 16];
        wdata_sel = req_wdata[16*j +: 16];
        sel_oh[j] = 1'b1;
      end
      if (owner == 3'(j)) begin
        own_oh[j] = 1'b1;
      end
    end
  end

  assign nxt_ptr = wrap({1'b0, owner} + 4'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      ptr          <= '0;
      cnt          <= '0;
      req_ack      <= '0;
      req_done     <= '0;
      req_err      <= '0;
      req_rdata    <= '0;
      owner        <= '0;
      arb_busy     <= 1'b0;
      m_start_tx   <= 1'b0;
      m_cmd_packet <= '0;
      m_data_wr    <= '0;
    end else begin
      m_start_tx <= 1'b0;
      req_ack    <= '0;
      req_done   <= '0;
      req_err    <= '0;
      unique case (state)
        S_IDLE: begin
          if (hit && !m_spi_busy) begin
            owner        <= sel;
            m_cmd_packet <= cmd_sel;
            m_data_wr    <= wdata_sel;
            m_start_tx   <= 1'b1;
            req_ack      <= sel_oh;
            arb_busy     <= 1'b1;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
          // A tx_done on the limit cycle still completes normally.
          if (m_tx_done) begin
            req_rdata <= m_data_rd;
            req_done  <= own_oh;
            state     <= S_DONE;
          end else if (cnt == LIMIT) begin
            req_err <= own_oh;
            state   <= S_ERR;
          end
        end
        S_DONE, S_ERR: begin
          ptr      <= nxt_ptr;
          arb_busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter: per-cycle vector table
// plus hand-written timeout and limit-cycle sequences.
module tb_spi_master_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [31:0] req_cmd;
  logic [31:0] req_wdata;
  logic [1:0]  req_ack;
  logic [1:0]  req_done;
  logic [1:0]  req_err;
  logic [15:0] req_rdata;
  logic [2:0]  owner;
  logic        arb_busy;
  logic        m_start_tx;
  logic [15:0] m_cmd_packet;
  logic [15:0] m_data_wr;
  logic        m_spi_busy;
  logic        m_tx_done;
  logic [15:0] m_data_rd;

  int checks;
  int errors;

  spi_master_arbiter #(
    .NUM_REQ(2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_cmd(req_cmd),
    .req_wdata(req_wdata),
    .req_ack(req_ack),
    .req_done(req_done),
    .req_err(req_err),
    .req_rdata(req_rdata),
    .owner(owner),
    .arb_busy(arb_busy),
    .m_start_tx(m_start_tx),
    .m_cmd_packet(m_cmd_packet),
    .m_data_wr(m_data_wr),
    .m_spi_busy(m_spi_busy),
    .m_tx_done(m_tx_done),
    .m_data_rd(m_data_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [1:0]  vld;
    logic        busy;
    logic        txd;
    logic [15:0] rd;
    logic [1:0]  ack;
    logic [1:0]  done;
    logic [1:0]  err;
    logic        st;
    logic        ab;
    logic [2:0]  own;
    logic [15:0] rdata;
    logic [15:0] cmd;
    logic [15:0] wr;
  } vec_t;

  vec_t tv[35];

  function automatic vec_t mk(
    input logic        r,
    input logic [1:0]  v,
    input logic        b,
    input logic        t,
    input logic [15:0] d,
    input logic [1:0]  a,
    input logic [1:0]  dn,
    input logic [1:0]  e,
    input logic        s,
    input logic        ab,
    input logic [2:0]  o,
    input logic [15:0] rdat,
    input logic [15:0] c
  );
    vec_t x;
    x.rst = r;   x.vld = v;   x.busy = b;
    x.txd = t;   x.rd = d;    x.ack = a;
    x.done = dn; x.err = e;   x.st = s;
    x.ab = ab;   x.own = o;   x.rdata = rdat;
    x.cmd = c;
    if (c == 16'h8123)      x.wr = 16'hA5A5;
    else if (c == 16'h9456) x.wr = 16'h5A5A;
    else                    x.wr = 16'h0000;
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  logic early;

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    req_valid  = 2'b00;
    req_cmd    = {16'h9456, 16'h8123};
    req_wdata  = {16'h5A5A, 16'hA5A5};
    m_spi_busy = 1'b0;
    m_tx_done  = 1'b0;
    m_data_rd  = 16'h0000;

    // rst vld bsy txd rd | ack done err st ab own rdata cmd
    tv[0]  = mk(1, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0,       0);
    tv[1]  = mk(0, 1, 0, 0, 0,       1, 0, 0, 1, 1, 0, 0,       'h8123);
    tv[2]  = mk(0, 0, 0, 0, 0,       0, 0, 0, 0, 1, 0, 0,       'h8123);
    tv[3]  = mk(0, 0, 0, 1, 'h3C3C,  0, 1, 0, 0, 1, 0, 'h3C3C,  'h8123);
    tv[4]  = mk(0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 'h3C3C,  'h8123);
    tv[5]  = mk(1, 3, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0,       0);
    tv[6]  = mk(0, 3, 0, 0, 0,       1, 0, 0, 1, 1, 0, 0,       'h8123);
    tv[7]  = mk(0, 3, 0, 0, 0,       0, 0, 0, 0, 1, 0, 0,       'h8123);
    tv[8]  = mk(0, 3, 0, 1, 'h1111,  0, 1, 0, 0, 1, 0, 'h1111,  'h8123);
    tv[9]  = mk(0, 3, 0, 0, 0,       0, 0, 0, 0, 0, 0, 'h1111,  'h8123);
    tv[10] = mk(0, 3, 0, 0, 0,       2, 0, 0, 1, 1, 1, 'h1111,  'h9456);
    tv[11] = mk(0, 3, 0, 0, 0,       0, 0, 0, 0, 1, 1, 'h1111,  'h9456);
    tv[12] = mk(0, 3, 0, 1, 'h2222,  0, 2, 0, 0, 1, 1, 'h2222,  'h9456);
    tv[13] = mk(0, 3, 0, 0, 0,       0, 0, 0, 0, 0, 1, 'h2222,  'h9456);
    tv[14] = mk(0, 3, 0, 0, 0,       1, 0, 0, 1, 1, 0, 'h2222,  'h8123);
    tv[15] = mk(0, 3, 0, 0, 0,       0, 0, 0, 0, 1, 0, 'h2222,  'h8123);
    tv[16] = mk(0, 3, 0, 1, 'h3333,  0, 1, 0, 0, 1, 0, 'h3333,  'h8123);
    tv[17] = mk(0, 3, 0, 0, 0,       0, 0, 0, 0, 0, 0, 'h3333,  'h8123);
    tv[18] = mk(0, 3, 0, 0, 0,       2, 0, 0, 1, 1, 1, 'h3333,  'h9456);
    tv[19] = mk(0, 3, 0, 0, 0,       0, 0, 0, 0, 1, 1, 'h3333,  'h9456);
    tv[20] = mk(0, 3, 0, 1, 'h4444,  0, 2, 0, 0, 1, 1, 'h4444,  'h9456);
    tv[21] = mk(0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 1, 'h4444,  'h9456);
    tv[22] = mk(0, 2, 0, 0, 0,       2, 0, 0, 1, 1, 1, 'h4444,  'h9456);
    tv[23] = mk(0, 0, 0, 0, 0,       0, 0, 0, 0, 1, 1, 'h4444,  'h9456);
    tv[24] = mk(1, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0,       0);
    tv[25] = mk(0, 3, 0, 1, 'hDEAD,  1, 0, 0, 1, 1, 0, 0,       'h8123);
    tv[26] = mk(0, 0, 0, 0, 0,       0, 0, 0, 0, 1, 0, 0,       'h8123);
    tv[27] = mk(0, 0, 0, 1, 'hABCD,  0, 1, 0, 0, 1, 0, 'hABCD,  'h8123);
    tv[28] = mk(0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 'hABCD,  'h8123);
    tv[29] = mk(0, 2, 1, 0, 0,       0, 0, 0, 0, 0, 0, 'hABCD,  'h8123);
    tv[30] = mk(0, 2, 1, 0, 0,       0, 0, 0, 0, 0, 0, 'hABCD,  'h8123);
    tv[31] = mk(0, 2, 0, 0, 0,       2, 0, 0, 1, 1, 1, 'hABCD,  'h9456);
    tv[32] = mk(0, 0, 0, 0, 0,       0, 0, 0, 0, 1, 1, 'hABCD,  'h9456);
    tv[33] = mk(0, 0, 0, 1, 'h5555,  0, 2, 0, 0, 1, 1, 'h5555,  'h9456);
    tv[34] = mk(0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 1, 'h5555,  'h9456);

    for (int i = 0; i < 35; i++) begin
      rst        = tv[i].rst;
      req_valid  = tv[i].vld;
      m_spi_busy = tv[i].busy;
      m_tx_done  = tv[i].txd;
      m_data_rd  = tv[i].rd;
      step();
      chk($sformatf("row%0d", i),
          64'({req_ack, req_done, req_err, m_start_tx, arb_busy,
               owner, req_rdata, m_cmd_packet, m_data_wr}),
          64'({tv[i].ack, tv[i].done, tv[i].err, tv[i].st, tv[i].ab,
               tv[i].own, tv[i].rdata, tv[i].cmd, tv[i].wr}));
    end

    // Timeout: 16 WAIT cycles without tx_done, ptr is 0 here.
    rst        = 1'b0;
    m_spi_busy = 1'b0;
    m_tx_done  = 1'b0;
    m_data_rd  = 16'h0000;
    req_valid  = 2'b01;
    step();
    chk("to_ack", 64'({req_ack, m_start_tx}), 64'({2'b01, 1'b1}));
    req_valid = 2'b00;
    step();
    early = 1'b0;
    repeat (15) begin
      step();
      if (req_err != 2'b00 || req_done != 2'b00 || !arb_busy)
        early = 1'b1;
    end
    chk("to_early", 64'(early), 64'd0);
    step();
    chk("to_err",
        64'({req_err, req_done, arb_busy, req_rdata}),
        64'({2'b01, 2'b00, 1'b1, 16'h5555}));
    step();
    chk("to_idle",
        64'({req_err, req_done, arb_busy, req_rdata}),
        64'({2'b00, 2'b00, 1'b0, 16'h5555}));

    // tx_done on the limit cycle; ptr is 1 after the timeout.
    req_valid = 2'b11;
    step();
    chk("lim_ack", 64'({req_ack, owner}), 64'({2'b10, 3'd1}));
    req_valid = 2'b00;
    step();
    repeat (15) step();
    m_tx_done = 1'b1;
    m_data_rd = 16'h7777;
    step();
    chk("lim_done",
        64'({req_done, req_err, req_rdata}),
        64'({2'b10, 2'b00, 16'h7777}));
    m_tx_done = 1'b0;
    m_data_rd = 16'h0000;
    step();
    chk("lim_after",
        64'({req_done, req_err, arb_busy}),
        64'({2'b00, 2'b00, 1'b0}));

    req_valid = 2'b11;
    step();
    chk("rr_wrap", 64'({req_ack, owner, m_cmd_packet}),
        64'({2'b01, 3'd0, 16'h8123}));
    req_valid = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
